// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads W0..W15, then emits W0..W63 from a sliding window.
// Optional ctrl_abort input is enabled by defining MSG_SCHED_ABORT_EN.
module sha256_msg_sched #(
    parameter int WORDS_IN  = 16,
    parameter int WORDS_OUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_start,
`ifdef MSG_SCHED_ABORT_EN
    input  logic        ctrl_abort,
`endif
    input  logic [31:0] data_in,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    output logic [31:0] data_out,
    output logic [5:0]  data_out_index,
    output logic        data_out_valid,
    input  logic        data_out_ready,
    output logic        ctrl_busy,
    output logic        ctrl_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [4:0]  load_cnt_q, load_cnt_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // Next schedule word from the window W[t..t+15] -> W[t+16]
    assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    assign data_out       = (state_q == S_EMIT) ? win_q[0] : 32'd0;
    assign data_out_index = (state_q == S_EMIT) ? t_q : 6'd0;

    always_comb begin
        state_d        = state_q;
        load_cnt_d     = load_cnt_q;
        t_d            = t_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        ctrl_busy      = 1'b0;
        ctrl_done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    state_d    = S_LOAD;
                    load_cnt_d = 5'd0;
                end
            end
            S_LOAD: begin
                data_in_ready = 1'b1;
                ctrl_busy     = 1'b1;
                if (data_in_valid) begin
                    win_d[load_cnt_q[3:0]] = data_in;
                    load_cnt_d = load_cnt_q + 5'd1;
                    if (load_cnt_q == 5'(WORDS_IN - 1)) begin
                        state_d = S_EMIT;
                        t_d     = 6'd0;
                    end
                end
            end
            S_EMIT: begin
                data_out_valid = 1'b1;
                ctrl_busy      = 1'b1;
                if (data_out_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[15] = w_new;
                    t_d       = t_q + 6'd1;
                    if (t_q == 6'(WORDS_OUT - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ctrl_done = 1'b1;
                state_d   = S_IDLE;
            end
        endcase

`ifdef MSG_SCHED_ABORT_EN
        // Abort wins over any handshake in the same cycle
        if (ctrl_abort && (state_q == S_LOAD || state_q == S_EMIT)) begin
            state_d    = S_IDLE;
            load_cnt_d = 5'd0;
            t_d        = 6'd0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            load_cnt_q <= 5'd0;
            t_q        <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed, table-driven bench for sha256_msg_sched.
// Reference schedule is recomputed in the bench from the input block.
module tb_sha256_msg_sched;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [31:0] data_out;
    logic [5:0]  data_out_index;
    logic        data_out_valid;
    logic        data_out_ready = 1'b0;
    logic        ctrl_busy;
    logic        ctrl_done;
`ifdef MSG_SCHED_ABORT_EN
    logic        ctrl_abort = 1'b0;
`endif

    sha256_msg_sched dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_start     (ctrl_start),
`ifdef MSG_SCHED_ABORT_EN
        .ctrl_abort     (ctrl_abort),
`endif
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_index (data_out_index),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .ctrl_busy      (ctrl_busy),
        .ctrl_done      (ctrl_done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    logic [31:0] blk [16];
    logic [31:0] ref_w [64];

    // Monitor state, sampled on the falling edge
    int          cyc = 0;
    int          n_acc = 0;
    int          done_cnt = 0;
    int          stab_bad = 0;
    int          ir_bad = 0;
    int          tm_bad = 0;
    int          last_hs = -10;
    logic [31:0] got_d [2048];
    logic [5:0]  got_i [2048];
    logic        hold_p = 1'b0;
    logic [31:0] hold_d = 32'd0;
    logic [5:0]  hold_i = 6'd0;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w15;
        bit          gap;
        bit          bp;
        bit          noise;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void build_ref();
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3);
            s1 = rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10);
            ref_w[i] = s1 + ref_w[i-7] + s0 + ref_w[i-16];
        end
    endfunction

    function automatic void set_blk(input logic [31:0] w0, input logic [31:0] w1,
                                    input logic [31:0] w15);
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = w0;
        blk[1]  = w1;
        blk[15] = w15;
    endfunction

    always @(negedge clock) begin
        cyc++;
        if (hold_p && (!data_out_valid || data_out !== hold_d ||
                       data_out_index !== hold_i))
            stab_bad++;
        hold_p = data_out_valid && !data_out_ready;
        hold_d = data_out;
        hold_i = data_out_index;
        if (data_in_ready && (!ctrl_busy || data_out_valid))
            ir_bad++;
        if (data_out_valid && data_out_ready) begin
            if (n_acc < 2048) begin
                got_d[n_acc] = data_out;
                got_i[n_acc] = data_out_index;
            end
            n_acc++;
            if (data_out_index == 6'd63) last_hs = cyc;
        end
        if (ctrl_done) begin
            done_cnt++;
            if (cyc != last_hs + 1) tm_bad++;
        end
    end

    task automatic load_block(input string nm, input bit gap, input bit noise);
        logic pre_v;
        pre_v = 1'b0;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_in       = blk[i];
            data_in_valid = 1'b1;
            if (noise) ctrl_start = 1'(i % 2);
            pre_v = data_out_valid;
            tick();
            if (gap && i == 7) begin
                data_in_valid = 1'b0;
                repeat (3) tick();
            end
        end
        check({nm, "_first_valid"}, {30'd0, pre_v, data_out_valid}, 32'd1);
        data_in_valid = noise;
        ctrl_start    = 1'b0;
    endtask

    task automatic run_block(input string nm, input bit gap, input bit bp,
                             input bit noise, output int base);
        int b_done, b_stab, b_ir, b_tm, k, n, bad_idx, bad_val;
        build_ref();
        base   = n_acc;
        b_done = done_cnt;
        b_stab = stab_bad;
        b_ir   = ir_bad;
        b_tm   = tm_bad;
        if (noise) begin
            data_in_valid = 1'b1;
            data_in       = 32'hdeadbeef;
            repeat (2) tick();
            data_in_valid = 1'b0;
        end
        load_block(nm, gap, noise);
        k = 0;
        while (done_cnt == b_done && k < 1000) begin
            data_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) ctrl_start = ~ctrl_start;
            tick();
            k++;
        end
        ctrl_start     = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) tick();
        n = n_acc - base;
        bad_idx = 0;
        bad_val = 0;
        for (int i = 0; i < 64 && i < n; i++) begin
            if (got_i[base + i] !== 6'(i)) bad_idx++;
            if (got_d[base + i] !== ref_w[i]) bad_val++;
        end
        check({nm, "_count"},    32'(n), 32'd64);
        check({nm, "_idx_seq"},  32'(bad_idx), 32'd0);
        check({nm, "_val_seq"},  32'(bad_val), 32'd0);
        check({nm, "_done_cnt"}, 32'(done_cnt - b_done), 32'd1);
        check({nm, "_done_tm"},  32'(tm_bad - b_tm), 32'd0);
        check({nm, "_stable"},   32'(stab_bad - b_stab), 32'd0);
        check({nm, "_in_ready"}, 32'(ir_bad - b_ir), 32'd0);
    endtask

    initial begin
        vec_t vecs [8];
        int   base, k, b_done;

        vecs[0] = '{32'h61626380, 32'h0, 32'h18, 1'b0, 1'b0, 1'b0, 16, 32'h61626380};
        vecs[1] = '{32'h61626380, 32'h0, 32'h18, 1'b0, 1'b0, 1'b0, 17, 32'h000F0000};
        vecs[2] = '{32'h61626380, 32'h0, 32'h18, 1'b0, 1'b1, 1'b0, 18, 32'h7DA86405};
        vecs[3] = '{32'h61626380, 32'h0, 32'h18, 1'b1, 1'b0, 1'b0, 16, 32'h61626380};
        vecs[4] = '{32'h61626380, 32'h0, 32'h18, 1'b0, 1'b0, 1'b1, 0,  32'h61626380};
        vecs[5] = '{32'h61626380, 32'h0, 32'h18, 1'b1, 1'b1, 1'b1, 15, 32'h00000018};
        vecs[6] = '{32'h0, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0, 16, 32'h11002000};
        vecs[7] = '{32'h0, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1,  32'h80000000};

        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", {31'd0, data_in_ready}, 32'd0);
        check("rst_valid",    {31'd0, data_out_valid}, 32'd0);
        check("rst_data",     data_out, 32'd0);
        check("rst_index",    32'(data_out_index), 32'd0);
        check("rst_busy",     {31'd0, ctrl_busy}, 32'd0);
        check("rst_done",     {31'd0, ctrl_done}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            set_blk(vecs[v].w0, vecs[v].w1, vecs[v].w15);
            run_block($sformatf("v%0d", v), vecs[v].gap, vecs[v].bp,
                      vecs[v].noise, base);
            check($sformatf("v%0d_w%0d", v, vecs[v].idx),
                  got_d[base + vecs[v].idx], vecs[v].exp);
        end

        // Reset in the middle of EMIT at t=30
        set_blk(32'h61626380, 32'h0, 32'h18);
        load_block("rst_mid", 1'b0, 1'b0);
        data_out_ready = 1'b1;
        k = 0;
        while (data_out_index != 6'd30 && k < 200) begin
            tick();
            k++;
        end
        check("rst_mid_reach30", 32'(data_out_index), 32'd30);
        b_done  = done_cnt;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_mid_valid", {31'd0, data_out_valid}, 32'd0);
        check("rst_mid_data",  data_out, 32'd0);
        check("rst_mid_index", 32'(data_out_index), 32'd0);
        check("rst_mid_busy",  {31'd0, ctrl_busy}, 32'd0);
        check("rst_mid_ready", {31'd0, data_in_ready}, 32'd0);
        repeat (3) tick();
        check("rst_mid_no_done", 32'(done_cnt - b_done), 32'd0);
        check("rst_mid_idle", {30'd0, ctrl_busy, data_out_valid}, 32'd0);
        run_block("fresh", 1'b0, 1'b0, 1'b0, base);
        check("fresh_w18", got_d[base + 18], 32'h7DA86405);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
SHA-256 message schedule expander. It accepts one 512-bit block as 16 big-endian 32-bit words W0..W15 and emits W0..W63 in order. W16..W63 are computed with the sigma0/sigma1 functions, which are built from the same rotate and logical-shift primitives as the ALU shift units. It sits between the block padder (upstream) and the compression round core (downstream), with valid/ready handshakes on both sides.

Parameters:
WORDS_IN, 16, words accepted per block; fixed by SHA-256, must not be overridden.
WORDS_OUT, 64, words emitted per block; fixed by SHA-256, must not be overridden.

Ports:
clock  input  1  single clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock
ctrl_start  input  1  begin a new block; sampled only in IDLE
data_in  input  32  message word, big-endian word order
data_in_valid  input  1  data_in holds a valid word
data_in_ready  output  1  block can accept a word this cycle
data_out  output  32  schedule word W[t]
data_out_index  output  6  t of current data_out (0..63)
data_out_valid  output  1  data_out/data_out_index valid
data_out_ready  input  1  downstream accepts data_out this cycle
ctrl_busy  output  1  high in LOAD or EMIT
ctrl_done  output  1  one-cycle pulse after W63 accepted

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; data_in_ready=0, data_out_valid=0, data_out=0, data_out_index=0, ctrl_busy=0, ctrl_done=0, window cleared, counters cleared. Reset applies mid-block: the partial block is discarded with no done pulse.
- State storage: 16x32 sliding window win[0..15] (holds W[t..t+15] during EMIT), 5-bit load counter, 6-bit emit counter t.
- IDLE: all handshake outputs low. ctrl_start=1 -> LOAD next cycle. data_in_valid is ignored.
- LOAD: data_in_ready=1, ctrl_busy=1.
  - Each data_in_valid&data_in_ready cycle writes data_in to win[load_cnt], then increments load_cnt.
  - On the 16th acceptance -> EMIT next cycle with t=0. data_in_ready drops in that same next cycle.
  - ctrl_start is ignored.
- EMIT: data_out_valid=1, data_out=win[0], data_out_index=t, data_in_ready=0.
  - First data_out_valid is one cycle after the 16th input handshake.
  - Under data_out_ready=0, data_out and data_out_index hold stable.
  - On data_out_valid&data_out_ready:
    - win[i] <= win[i+1] for i=0..14.
    - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32 (carry discarded).
    - t <= t+1.
  - win[15] is computed on every shift. Values computed when t>=48 are never emitted; this is harmless.
  - Handshake at t=63 -> DONE.
- DONE: single cycle. ctrl_done=1, data_out_valid=0, ctrl_busy=0, then -> IDLE. ctrl_start is ignored in DONE.
- sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- SHR is a logical shift (zero fill), not arithmetic.
- Throughput: one word per cycle when data_out_ready is held high. A block takes 16 + 64 + 1 = 81 cycles minimum from the first load handshake to the end of DONE.

Optional Feature:
Macro MSG_SCHED_ABORT_EN.
- Defined: adds input ctrl_abort (1 bit). ctrl_abort=1 in LOAD or EMIT -> IDLE next cycle, with outputs as in reset and no ctrl_done. The window contents are don't-care. ctrl_abort has priority over a simultaneous handshake.
- Undefined: no port is added. A block always runs to DONE unless reset_n is asserted.

Test Plan:
1. "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, data_out_ready held 1. Required: W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; data_out_index runs 0..63 contiguously; ctrl_done pulses exactly once, one cycle after the W63 handshake.
2. Backpressure: run the "abc" block with data_out_ready toggled pseudo-randomly. Required: the word sequence matches case 1, data_out is stable whenever valid&!ready, and there are no duplicated or skipped indices.
3. Load gaps: deassert data_in_valid for 3 cycles between words 7 and 8. Required: the same 64 outputs as case 1, and data_out_valid first rises one cycle after the 16th input handshake.
4. Protocol ignores: pulse ctrl_start during LOAD and EMIT, and drive data_in_valid=1 in IDLE and EMIT. Required: the output sequence is unchanged and data_in_ready=0 outside LOAD.
5. Reset mid-EMIT: reset_n=0 for one edge at t=30. Required: all outputs 0 at the following cycle, no ctrl_done, state IDLE. A fresh "abc" block then reproduces case 1.
6. Sigma shift check: W1=0x80000000, all other input words 0. Required: W16 = sigma0(0x80000000) = 0x11002000, which confirms SHR3 zero-fills rather than sign-extending.
